alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 18 +
 rtl/alu_arbiter_alu.sv | 28 ++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: ALU opcodes and the
// response-holding FSM state type.
package alu_arbiter_pkg;

    // ALU operation codes (4-bit encodings, zero-extended to OPCODE_LENGTH)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_EQ  = 4'b1000;

    // IDLE: no result held (rsp_valid=0); HOLD: result register valid
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by both requesters. Arithmetic wraps
// modulo 2^DATA_WIDTH; unknown opcodes produce zero.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    a_i,
    input  logic [DATA_WIDTH-1:0]    b_i,
    input  logic [OPCODE_LENGTH-1:0] op_i,
    output logic [DATA_WIDTH-1:0]    result_o
);

    // Decode the opcode and compute the result; default keeps it latch-free
    always_comb begin
        result_o = '0;
        case (op_i)
            OPCODE_LENGTH'(ALU_AND): result_o = a_i & b_i;
            OPCODE_LENGTH'(ALU_OR):  result_o = a_i | b_i;
            OPCODE_LENGTH'(ALU_ADD): result_o = a_i + b_i;
            OPCODE_LENGTH'(ALU_SUB): result_o = a_i - b_i;
            OPCODE_LENGTH'(ALU_EQ):  result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i == b_i)};
            default:                 result_o = '0;
        endcase
    end

endmodule : alu_arbiter_alu

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter. The accepted
// operation's result is registered and offered on a single response port.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Request side: reqN_valid may rise or fall at any time; the
// arbiter raises at most one reqN_ready per cycle, never during reset, and
// only when the response register is empty or being drained this cycle.
// Response side: rsp_valid stays high with rsp_data/rsp_id stable until
// rsp_ready is sampled high; rsp_ready while rsp_valid=0 has no effect.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output arb_state_e               dbg_state_o
);

    arb_state_e             state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;

    logic                   both_valid;
    logic                   any_valid;
    logic                   grant_id;
    logic                   can_take;
    logic                   accept;

    logic [DATA_WIDTH-1:0]    alu_a;
    logic [DATA_WIDTH-1:0]    alu_b;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_result;

    // Round-robin grant and accept decision
    always_comb begin
        both_valid = req0_valid && req1_valid;
        any_valid  = req0_valid || req1_valid;
        // Contention goes to the requester that did not win last; otherwise
        // the lone valid requester (req0 index when nobody is valid).
        if (both_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
        can_take   = (state_q == ST_IDLE) || rsp_ready;
        accept     = any_valid && can_take && !reset;
        req0_ready = accept && !grant_id;
        req1_ready = accept &&  grant_id;
    end

    // Operand mux feeding the single shared ALU
    always_comb begin
        alu_a  = grant_id ? req1_a  : req0_a;
        alu_b  = grant_id ? req1_b  : req0_b;
        alu_op = grant_id ? req1_op : req0_op;
    end

    alu_arbiter_alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_result)
    );

    // FSM next state plus result/pointer next values; an accept always
    // reloads the result register, even while the old one is being drained
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept)         state_d = ST_HOLD;
                else if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            last_grant_d = grant_id;
            rsp_id_d     = grant_id;
            rsp_data_d   = alu_result;
        end
    end

    // State, pointer and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid   = (state_q == ST_HOLD);
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign dbg_state_o = state_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int OW = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic [W-1:0]  req0_a = '0;
    logic [W-1:0]  req0_b = '0;
    logic [OW-1:0] req0_op = '0;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic [W-1:0]  req1_a = '0;
    logic [W-1:0]  req1_b = '0;
    logic [OW-1:0] req1_op = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [W-1:0]  rsp_data;
    arb_state_e    dbg_state_o;

    alu_arbiter #(.DATA_WIDTH(W), .OPCODE_LENGTH(OW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0] exp_q[$];     // results the consumer has yet to take
    logic         exp_id_q[$];  // owner of each queued result
    int           last_winner = 1;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [OW-1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint unsigned m = 64'd1 << W;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return W'((longint'(a) + longint'(b)) % m);
            4'd6:    return W'((longint'(a) + m - longint'(b)) % m);
            4'd8:    return (a == b) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle of inputs at the falling edge, check the DUT against
    // the model, then advance the model at the rising edge.
    task automatic step(input logic rst, input logic rr,
                        input logic v0, input logic [OW-1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic v1, input logic [OW-1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        logic pending;
        logic room;
        int   winner;
        logic take0, take1;
        @(negedge clk);
        reset = rst; rsp_ready = rr;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        #1;
        pending = (exp_q.size() != 0);
        room    = !pending || rr;
        if (v0 && v1)  winner = 1 - last_winner;
        else if (v1)   winner = 1;
        else if (v0)   winner = 0;
        else           winner = -1;
        take0 = !rst && room && (winner == 0);
        take1 = !rst && room && (winner == 1);
        check("req0_ready", W'(req0_ready), W'(take0));
        check("req1_ready", W'(req1_ready), W'(take1));
        check("rsp_valid",  W'(rsp_valid),  W'(pending));
        check("dbg_state",  W'(dbg_state_o == ST_HOLD), W'(pending));
        if (pending) begin
            check("rsp_data", rsp_data, exp_q[0]);
            check("rsp_id",   W'(rsp_id), W'(exp_id_q[0]));
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_id_q.delete();
            last_winner = 1;
        end else begin
            if (pending && rr) begin
                void'(exp_q.pop_front());
                void'(exp_id_q.pop_front());
            end
            if (take0) begin
                exp_q.push_back(ref_alu(op0, a0, b0));
                exp_id_q.push_back(1'b0);
                last_winner = 0;
            end else if (take1) begin
                exp_q.push_back(ref_alu(op1, a1, b1));
                exp_id_q.push_back(1'b1);
                last_winner = 1;
            end
        end
    endtask

    task automatic idle(input logic rst, input logic rr);
        step(rst, rr, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset, with both requesters knocking: nobody may be accepted
        step(1'b1, 1'b1, 1'b1, 4'd2, 32'd1, 32'd1, 1'b1, 4'd2, 32'd2, 32'd2);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
        #1;
        check("reset_rsp_valid", W'(rsp_valid), '0);
        check("reset_rsp_id",    W'(rsp_id),    '0);
        check("reset_rsp_data",  rsp_data,      '0);

        // req0 ADD 5+7 alone
        step(1'b0, 1'b1, 1'b1, 4'b0010, 32'd5, 32'd7, 1'b0, '0, '0, '0);
        #1;
        check("add_valid", W'(rsp_valid), 32'd1);
        check("add_id",    W'(rsp_id),    32'd0);
        check("add_data",  rsp_data,      32'd12);
        idle(1'b0, 1'b1);

        // continuous contention: alternating grants, one result per cycle
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 4'b0110, 32'd10, 32'd3, 1'b1, 4'b0000, 32'hF0, 32'h3C);
            #1;
            check("rr_valid", W'(rsp_valid), 32'd1);
            check("rr_data", rsp_data, (rsp_id == 1'b0) ? 32'd7 : 32'h30);
        end
        idle(1'b0, 1'b1);

        // backpressure: req1 SUB 0-1 then consumer stalls for 3 cycles
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 4'b0110, 32'd0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'b0001, 32'h11, 32'h22, 1'b1, 4'b0010, 32'd4, 32'd4);
            #1;
            check("bp_data", rsp_data, 32'hFFFF_FFFF);
            check("bp_id",   W'(rsp_id), 32'd1);
        end
        // release: drain and accept in the same cycle
        step(1'b0, 1'b1, 1'b1, 4'b0001, 32'h11, 32'h22, 1'b0, '0, '0, '0);
        #1;
        check("bp_new_data", rsp_data, 32'h33);
        idle(1'b0, 1'b1);

        // EQUAL then an undefined opcode
        step(1'b0, 1'b1, 1'b1, 4'b1000, 32'h1234, 32'h1234, 1'b0, '0, '0, '0);
        #1;
        check("eq_true", rsp_data, 32'd1);
        step(1'b0, 1'b1, 1'b1, 4'b0111, 32'h1234, 32'h1234, 1'b0, '0, '0, '0);
        #1;
        check("bad_op", rsp_data, 32'd0);
        idle(1'b0, 1'b1);

        // reset while holding a result, then contention must favour req0
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 4'b0010, 32'd9, 32'd9);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        #1;
        check("rst_hold_valid", W'(rsp_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 4'b0001, 32'hA0, 32'h0B, 1'b1, 4'b0000, 32'hFF, 32'hFF);
        #1;
        check("post_rst_id",   W'(rsp_id), 32'd0);
        check("post_rst_data", rsp_data,   32'hAB);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] a0, b0, a1, b1;
            a0 = $urandom(); b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom();
            a1 = $urandom(); b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom();
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 2) != 0), OW'($urandom_range(0, 15)), a0, b0,
                 ($urandom_range(0, 2) != 0), OW'($urandom_range(0, 15)), a1, b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_arbiter
